// File: rtl/exposition_pkg.sv
// Shared types and constants for the exposition_meter block.
package exposition_pkg;

  // Default counter / result width, matching the exposure generator's 33-bit values
  localparam int CNT_W_DEFAULT = 33;

  // Saturation value of a default-width counter
  localparam logic [CNT_W_DEFAULT-1:0] CNT_MAX = '1;

  // Measurement FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    DONE      = 2'd3
  } state_t;

endpackage

// File: rtl/ex_sync.sv
// Two-flop synchronizer / two-stage delay with asynchronous active-low reset.
// Used both to bring Ex_in into the clk_Ms domain and to give Ms_launch the
// same latency, so launch and exposure edges line up cycle-for-cycle.
module ex_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  // Two capture stages; the first may go metastable on an asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/exposition_meter.sv
// exposition_meter: measures the delay from a launch edge to the rising edge
// of an external exposure pulse, and the pulse's high duration, in clk_Ms
// cycles. Counters saturate rather than wrap.
// Optional feature: define EXPOSITION_METER_TIMEOUT_EN to abort a phase after
// MAX_WAIT cycles and flag it on Ms_err; otherwise Ms_err stays 0.
module exposition_meter
  import exposition_pkg::*;
#(
  parameter int               CNT_W    = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] MAX_WAIT = 33'h1_0000_0000
) (
  input  logic             clk_Ms,
  input  logic             rst_n,
  input  logic             Ms_launch,
  input  logic             Ex_in,
  output logic [CNT_W-1:0] delay_meas,
  output logic [CNT_W-1:0] duration_meas,
  output logic             Ms_valid,
  output logic             Ms_busy,
  output logic             Ms_err
);

`ifdef EXPOSITION_METER_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_ALL1 = '1;

  logic             ex_s;
  logic             l_s;
  logic             ex_prev_q;
  logic             l_prev_q;
  logic             launch_edge;
  logic             ex_rise;
  logic             ex_fall;
  logic             timeout_hit;
  logic [CNT_W-1:0] cnt_inc;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] delay_reg_q, delay_reg_d;
  logic [CNT_W-1:0] delay_meas_q, delay_meas_d;
  logic [CNT_W-1:0] duration_meas_q, duration_meas_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  ex_sync u_ex_sync (
    .clk   (clk_Ms),
    .rst_n (rst_n),
    .d     (Ex_in),
    .q     (ex_s)
  );

  ex_sync u_launch_sync (
    .clk   (clk_Ms),
    .rst_n (rst_n),
    .d     (Ms_launch),
    .q     (l_s)
  );

  // Previous-value flops for edge detection on the aligned signals
  always_ff @(posedge clk_Ms or negedge rst_n) begin
    if (!rst_n) begin
      ex_prev_q <= 1'b0;
      l_prev_q  <= 1'b0;
    end else begin
      ex_prev_q <= ex_s;
      l_prev_q  <= l_s;
    end
  end

  assign launch_edge = l_s & ~l_prev_q;
  assign ex_rise     = ex_s & ~ex_prev_q;
  assign ex_fall     = ~ex_s & ex_prev_q;

  // Saturating increment: the counter sticks at all-ones
  assign cnt_inc     = (cnt_q == CNT_ALL1) ? cnt_q : cnt_q + 1'b1;
  assign timeout_hit = TIMEOUT_EN && (cnt_q >= MAX_WAIT);

  // FSM, counter and result registers
  always_ff @(posedge clk_Ms or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      delay_reg_q     <= '0;
      delay_meas_q    <= '0;
      duration_meas_q <= '0;
      valid_q         <= 1'b0;
      busy_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      delay_reg_q     <= delay_reg_d;
      delay_meas_q    <= delay_meas_d;
      duration_meas_q <= duration_meas_d;
      valid_q         <= valid_d;
      busy_q          <= busy_d;
      err_q           <= err_d;
    end
  end

  // Next-state logic; results are loaded on the transition into DONE so that
  // Ms_valid and the new values appear together during the DONE cycle
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    delay_reg_d     = delay_reg_q;
    delay_meas_d    = delay_meas_q;
    duration_meas_d = duration_meas_q;
    valid_d         = 1'b0;
    busy_d          = busy_q;
    err_d           = err_q;

    unique case (state_q)
      IDLE: begin
        // An Ex edge coinciding with the launch edge is deliberately not
        // counted: WAIT_RISE only reacts to edges seen after entry.
        if (launch_edge) begin
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = WAIT_RISE;
        end
      end

      WAIT_RISE: begin
        cnt_d = cnt_inc;
        if (ex_rise) begin
          delay_reg_d = cnt_inc;
          cnt_d       = '0;
          state_d     = HIGH;
        end else if (timeout_hit) begin
          delay_meas_d    = MAX_WAIT;
          duration_meas_d = '0;
          err_d           = 1'b1;
          valid_d         = 1'b1;
          busy_d          = 1'b0;
          state_d         = DONE;
        end
      end

      HIGH: begin
        cnt_d = cnt_inc;
        if (ex_fall) begin
          delay_meas_d    = delay_reg_q;
          duration_meas_d = cnt_inc;
          err_d           = 1'b0;
          valid_d         = 1'b1;
          busy_d          = 1'b0;
          state_d         = DONE;
        end else if (timeout_hit) begin
          delay_meas_d    = delay_reg_q;
          duration_meas_d = MAX_WAIT;
          err_d           = 1'b1;
          valid_d         = 1'b1;
          busy_d          = 1'b0;
          state_d         = DONE;
        end
      end

      DONE: begin
        // One-cycle strobe state; launch edges seen here are dropped
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign delay_meas    = delay_meas_q;
  assign duration_meas = duration_meas_q;
  assign Ms_valid      = valid_q;
  assign Ms_busy       = busy_q;
  assign Ms_err        = err_q;

endmodule

// File: tb/tb_exposition_meter.sv
// Scoreboard bench for exposition_meter. Expected results are queued when a
// measurement is driven and compared when Ms_valid fires.
module tb_exposition_meter;
  import exposition_pkg::*;

  localparam int CW = 33;
`ifdef EXPOSITION_METER_TIMEOUT_EN
  localparam logic [CW-1:0] MW = 33'd50;
`else
  localparam logic [CW-1:0] MW = 33'h1_0000_0000;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          Ms_launch = 1'b0;
  logic          Ex_in = 1'b0;
  logic [CW-1:0] delay_meas;
  logic [CW-1:0] duration_meas;
  logic          Ms_valid;
  logic          Ms_busy;
  logic          Ms_err;

  typedef struct {
    longint delay;
    longint dur;
    longint err;
    longint cyc;
  } exp_t;

  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_pass = 0;
  longint cyc = 0;
  longint last_delay = 0;
  longint last_dur = 0;

  exposition_meter #(
    .CNT_W    (CW),
    .MAX_WAIT (MW)
  ) dut (
    .clk_Ms        (clk),
    .rst_n         (rst_n),
    .Ms_launch     (Ms_launch),
    .Ex_in         (Ex_in),
    .delay_meas    (delay_meas),
    .duration_meas (duration_meas),
    .Ms_valid      (Ms_valid),
    .Ms_busy       (Ms_busy),
    .Ms_err        (Ms_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, got, want);
  endtask

  // Pop and compare one expected result per Ms_valid strobe
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && Ms_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        $display("txn: cyc=%0d delay=%0d dur=%0d err=%0d (want cyc=%0d delay=%0d dur=%0d err=%0d)",
                 cyc, delay_meas, duration_meas, Ms_err, e.cyc, e.delay, e.dur, e.err);
        check("valid_cycle", cyc, e.cyc);
        check("delay_meas", delay_meas, e.delay);
        check("duration_meas", duration_meas, e.dur);
        check("ms_err", Ms_err, e.err);
        check("busy_at_valid", Ms_busy, 0);
      end
    end
  end

  // One measurement: launch at relative cycle 0 (held 2 cycles), Ex high in
  // [r, f). pre_fall >= 0 means Ex is already high before launch and falls at
  // pre_fall. extra_launch >= 0 adds a second launch pulse at that cycle.
  task automatic run_meas(input int r, input int f, input int pre_fall, input int extra_launch);
    longint t0;
    if (pre_fall >= 0) begin
      Ex_in = 1'b1;
      repeat (4) @(posedge clk);
      #1;
    end
    t0 = cyc;
    exp_q.push_back('{longint'(r), longint'(f - r), 64'd0, t0 + f + 3});
    for (int k = 0; k <= f + 3; k++) begin
      Ms_launch = (k < 2) || (extra_launch >= 0 && (k == extra_launch || k == extra_launch + 1));
      if (pre_fall >= 0 && k < pre_fall) Ex_in = 1'b1;
      else Ex_in = (k >= r && k < f);
      if (k == 2) check("busy_before", Ms_busy, 0);
      if (k == 3) check("busy_rise", Ms_busy, 1);
      if (k == f + 2) begin
        check("busy_mid", Ms_busy, 1);
        check("hold_delay", delay_meas, last_delay);
        check("hold_dur", duration_meas, last_dur);
      end
      @(posedge clk);
      #1;
    end
    last_delay = r;
    last_dur   = f - r;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", Ms_valid, 0);
    check("rst_busy", Ms_busy, 0);
    check("rst_err", Ms_err, 0);
    check("rst_delay", delay_meas, 0);
    check("rst_dur", duration_meas, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Basic pulse, Ex already high across launch, and ignored second launch
    run_meas(10, 25, -1, -1);
    run_meas(20, 21, 5, -1);
    run_meas(20, 21, 5, 12);

    // Reset in the middle of a measurement
    for (int k = 0; k < 15; k++) begin
      Ms_launch = (k < 2);
      Ex_in     = (k >= 10);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_valid", Ms_valid, 0);
    check("midrst_busy", Ms_busy, 0);
    check("midrst_err", Ms_err, 0);
    check("midrst_delay", delay_meas, 0);
    check("midrst_dur", duration_meas, 0);
    Ex_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_delay = 0;
    last_dur   = 0;
    repeat (10) @(posedge clk);
    #1;
    run_meas(4, 9, -1, -1);

    // Minimum pulse, long pulse, then back-to-back relaunch
    run_meas(1, 2, -1, -1);
    run_meas(7, 40, -1, -1);
    run_meas(3, 10, -1, -1);

`ifdef EXPOSITION_METER_TIMEOUT_EN
    // No pulse at all: WAIT_RISE times out after MAX_WAIT counts
    begin
      longint t0;
      t0 = cyc;
      exp_q.push_back('{longint'(MW), 64'd0, 64'd1, t0 + 54});
      for (int k = 0; k <= 55; k++) begin
        Ms_launch = (k < 2);
        Ex_in     = 1'b0;
        @(posedge clk);
        #1;
      end
      last_delay = MW;
      last_dur   = 0;
    end
`endif

    repeat (5) @(posedge clk);
    #1;
    check("final_hold_delay", delay_meas, last_delay);
    check("final_hold_dur", duration_meas, last_dur);
    check("pending_results", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
